// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, counter width and the
// colour-bar palette for the optional test pattern (VGA_TEST_PATTERN_EN).
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int CNT_W     = 10;

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525
  localparam int H_SYNC_START = H_VISIBLE + H_FP;                  // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;             // 752, exclusive
  localparam int V_SYNC_START = V_VISIBLE + V_FP;                  // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;             // 492, exclusive

  // 4 bits per channel, {R,G,B}
  localparam logic [11:0] RGB_WHITE   = 12'hFFF;
  localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
  localparam logic [11:0] RGB_CYAN    = 12'h0FF;
  localparam logic [11:0] RGB_GREEN   = 12'h0F0;
  localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
  localparam logic [11:0] RGB_RED     = 12'hF00;
  localparam logic [11:0] RGB_BLUE    = 12'h00F;
  localparam logic [11:0] RGB_BLACK   = 12'h000;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_tick_edge_detect.sv
// vga_tick_edge_detect: rising-edge detector for a level that is already
// synchronous to clk (no synchronizer).
//   clk, rst_n : clock, async active-low reset
//   level      : sampled level (pixel clock from the divider)
//   rise       : combinational one-cycle pulse, level & ~previous level
// prev resets to 1 so a level that is already high at reset release does
// not look like an edge.
module vga_tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator advanced by rising edges of the
// divided pixel clock, sampled in the clk domain.
//   clk, rst_n   : system clock, async active-low reset
//   divided_clk  : pixel clock level (same domain as clk)
//   pixel_tick   : one-clk pulse, outputs were just updated
//   hsync, vsync : active-low syncs
//   video_on     : visible region
//   pixel_x/y    : current h/v counts
//   frame_start  : one-clk pulse on entering (0,0)
//   test_rgb     : colour bars, only with VGA_TEST_PATTERN_EN defined
// All decoded outputs are registered from the *next* counter values so
// they change on the same clk edge as pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             divided_clk,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]      test_rgb
`endif
);
  import vga_timing_pkg::*;

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             tick;
  logic [CNT_W-1:0] h_next, v_next;
  logic             hs_next, vs_next, vid_next, fs_next;

  vga_tick_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (divided_clk),
    .rise  (tick)
  );

  always_comb begin
    h_next = (pixel_x == H_LAST) ? '0 : pixel_x + CNT_W'(1);
    v_next = pixel_y;
    if (pixel_x == H_LAST)
      v_next = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
    hs_next  = !((h_next >= CNT_W'(HS_START)) && (h_next < CNT_W'(HS_END)));
    vs_next  = !((v_next >= CNT_W'(VS_START)) && (v_next < CNT_W'(VS_END)));
    vid_next = (h_next < CNT_W'(H_VISIBLE)) && (v_next < CNT_W'(V_VISIBLE));
    fs_next  = (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      pixel_x     <= h_next;
      pixel_y     <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      video_on    <= vid_next;
      pixel_tick  <= 1'b1;
      frame_start <= fs_next;
    end else begin
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Eight equal-width bars across the visible line (80 px at 640).
  localparam int BAR_W = H_VISIBLE / 8;
  logic [CNT_W-1:0] bar_q;
  assign bar_q = h_next / CNT_W'(BAR_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    test_rgb <= '0;
    else if (tick) test_rgb <= vid_next ? bar_colour(bar_q[2:0]) : 12'h000;
  end
`endif

endmodule
